data_memory_arbiter: RTL and testbench

Arbitrates the single-port data memory between two requesters: port A, the instruction-fetch path (read-only), and port B, the load/store path (read/write). Each granted request becomes one memory transaction with a fixed 3-cycle sequence. Ties are broken round-robin. The block sits between the CPU datapath and the datamemory instance and is the only driver of the memory's address, write-enable and write-data inputs.

---
 rtl/data_memory_arbiter_if.sv | 25 ++
 rtl/data_memory_arbiter.sv | 54 +++++
 tb/tb_data_memory_arbiter.sv | 135 +++++++++++++
 3 files changed

// File: rtl/data_memory_arbiter_if.sv
// data_memory_arbiter_if: requester ports A/B (req, addr, we, wdata, ack, rdata) plus datamemory address/we/data bus
interface data_memory_arbiter_if #(parameter int ADDR_WIDTH = 7, parameter int DATA_WIDTH = 32);
  logic                  reqA;
  logic [ADDR_WIDTH-1:0] addrA;
  logic                  ackA;
  logic [DATA_WIDTH-1:0] rdataA;
  logic                  reqB;
  logic                  weB;
  logic [ADDR_WIDTH-1:0] addrB;
  logic [DATA_WIDTH-1:0] wdataB;
  logic                  ackB;
  logic [DATA_WIDTH-1:0] rdataB;
  logic [ADDR_WIDTH-1:0] memAddress;
  logic                  memWriteEnable;
  logic [DATA_WIDTH-1:0] memDataIn;
  logic [DATA_WIDTH-1:0] memDataOut;
  modport slave (
    input  reqA, addrA, reqB, weB, addrB, wdataB, memDataOut,
    output ackA, rdataA, ackB, rdataB, memAddress, memWriteEnable, memDataIn
  );
  modport master (
    output reqA, addrA, reqB, weB, addrB, wdataB, memDataOut,
    input  ackA, rdataA, ackB, rdataB, memAddress, memWriteEnable, memDataIn
  );
endinterface

// File: rtl/data_memory_arbiter.sv
// data_memory_arbiter: round-robin IDLE/BUSY/DONE arbiter of one data memory between port A (read) and port B (read/write); clk, reset, bus (slave modport)
module data_memory_arbiter #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 32
) (
  input logic clk,
  input logic reset,
  data_memory_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_d;
  logic win_b, last_b, we_r, grant, pick_b;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [DATA_WIDTH-1:0] wdata_r, rdata_a, rdata_b;
  always_comb begin
    pick_b  = bus.reqB && (!bus.reqA || !last_b);
    grant   = state == IDLE && (bus.reqA || bus.reqB);
    state_d = state == IDLE ? (grant ? BUSY : IDLE) : state == BUSY ? DONE : IDLE;
  end
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_d;
  always_ff @(posedge clk) begin
    if (reset) begin
      win_b   <= 1'b0;
      last_b  <= 1'b1;
      we_r    <= 1'b0;
      addr_r  <= '0;
      wdata_r <= '0;
      rdata_a <= '0;
      rdata_b <= '0;
    end else begin
      if (grant) begin
        win_b  <= pick_b;
        addr_r <= pick_b ? bus.addrB : bus.addrA;
        we_r   <= pick_b && bus.weB;
        if (pick_b) wdata_r <= bus.wdataB;
      end
      if (state == DONE) begin
        last_b <= win_b;
        if (!we_r && win_b) rdata_b <= bus.memDataOut;
        if (!we_r && !win_b) rdata_a <= bus.memDataOut;
      end
    end
  end
  // ack is gated by reset so a transaction aborted in its DONE cycle never signals completion
  assign bus.ackA           = state == DONE && !win_b && !reset;
  assign bus.ackB           = state == DONE && win_b && !reset;
  assign bus.rdataA         = rdata_a;
  assign bus.rdataB         = rdata_b;
  assign bus.memAddress     = addr_r;
  assign bus.memDataIn      = wdata_r;
  assign bus.memWriteEnable = state == BUSY && we_r;
endmodule

// File: tb/tb_data_memory_arbiter.sv
// tb_data_memory_arbiter: directed self-checking bench with a registered-read memory model behind the arbiter
module tb_data_memory_arbiter;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int failures = 0;
  logic [31:0] mem [128];
  logic [1:0] exp_ack [12] = '{2'b00, 2'b10, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b01, 2'b00};
  data_memory_arbiter_if bus ();
  data_memory_arbiter dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (bus.memWriteEnable) mem[bus.memAddress] <= bus.memDataIn;
    bus.memDataOut <= mem[bus.memAddress];
  end
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'h1000_0000 + i;
    reset = 1'b1;
    bus.reqA = 1'b0; bus.addrA = '0; bus.reqB = 1'b0; bus.weB = 1'b0; bus.addrB = '0; bus.wdataB = '0;
    tick(); tick();
    chk("rst_ackA", {31'b0, bus.ackA}, 0);
    chk("rst_ackB", {31'b0, bus.ackB}, 0);
    chk("rst_rdataA", bus.rdataA, 0);
    chk("rst_rdataB", bus.rdataB, 0);
    chk("rst_addr", {25'b0, bus.memAddress}, 0);
    chk("rst_din", bus.memDataIn, 0);
    chk("rst_we", {31'b0, bus.memWriteEnable}, 0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_we", {31'b0, bus.memWriteEnable}, 0);
      chk("idle_acks", {30'b0, bus.ackA, bus.ackB}, 0);
    end
    bus.reqB = 1'b1; bus.weB = 1'b1; bus.addrB = 7'd5; bus.wdataB = 32'hDEADBEEF;
    tick();
    chk("wr_busy_we", {31'b0, bus.memWriteEnable}, 1);
    chk("wr_busy_addr", {25'b0, bus.memAddress}, 5);
    chk("wr_busy_din", bus.memDataIn, 32'hDEADBEEF);
    chk("wr_busy_ackB", {31'b0, bus.ackB}, 0);
    tick();
    chk("wr_done_ackB", {31'b0, bus.ackB}, 1);
    chk("wr_done_we", {31'b0, bus.memWriteEnable}, 0);
    chk("wr_done_addr", {25'b0, bus.memAddress}, 5);
    bus.reqB = 1'b0; bus.weB = 1'b0;
    tick();
    chk("wr_idle_ackB", {31'b0, bus.ackB}, 0);
    chk("wr_rdataB_kept", bus.rdataB, 0);
    chk("wr_mem5", mem[5], 32'hDEADBEEF);
    bus.reqA = 1'b1; bus.addrA = 7'd5;
    tick();
    chk("rdA_busy_we", {31'b0, bus.memWriteEnable}, 0);
    chk("rdA_busy_addr", {25'b0, bus.memAddress}, 5);
    tick();
    chk("rdA_done_acks", {30'b0, bus.ackA, bus.ackB}, 2'b10);
    bus.reqA = 1'b0;
    tick();
    chk("rdA_rdataA", bus.rdataA, 32'hDEADBEEF);
    chk("rdA_idle_ackA", {31'b0, bus.ackA}, 0);
    reset = 1'b1;
    bus.reqA = 1'b1; bus.addrA = 7'd5; bus.reqB = 1'b1; bus.weB = 1'b0; bus.addrB = 7'd5;
    tick();
    chk("tie_rst_rdataA", bus.rdataA, 0);
    reset = 1'b0;
    tick();
    chk("tie_busy_addr", {25'b0, bus.memAddress}, 5);
    tick();
    chk("tie_first_acks", {30'b0, bus.ackA, bus.ackB}, 2'b10);
    bus.reqA = 1'b0;
    tick();
    chk("tie_rdataA", bus.rdataA, 32'hDEADBEEF);
    tick();
    tick();
    chk("tie_second_acks", {30'b0, bus.ackA, bus.ackB}, 2'b01);
    bus.reqB = 1'b0;
    tick();
    chk("tie_rdataB", bus.rdataB, 32'hDEADBEEF);
    bus.reqA = 1'b1; bus.addrA = 7'd1; bus.reqB = 1'b1; bus.addrB = 7'd2;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk($sformatf("rr_acks_%0d", i), {30'b0, bus.ackA, bus.ackB}, {30'b0, exp_ack[i]});
      if (i == 8) chk("rr_rdataA", bus.rdataA, 32'h1000_0001);
    end
    bus.reqA = 1'b0; bus.reqB = 1'b0;
    chk("rr_rdataB", bus.rdataB, 32'h1000_0002);
    bus.reqB = 1'b1; bus.weB = 1'b0; bus.addrB = 7'd5;
    tick();
    bus.addrB = 7'd9; bus.reqB = 1'b0;
    chk("late_busy_addr", {25'b0, bus.memAddress}, 5);
    tick();
    chk("late_done_ackB", {31'b0, bus.ackB}, 1);
    chk("late_done_addr", {25'b0, bus.memAddress}, 5);
    tick();
    chk("late_rdataB", bus.rdataB, 32'hDEADBEEF);
    chk("late_idle_ackB", {31'b0, bus.ackB}, 0);
    bus.reqA = 1'b1; bus.addrA = 7'd1;
    tick();
    bus.reqA = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    chk("abort_done_ackA", {31'b0, bus.ackA}, 0);
    tick();
    chk("abort_rdataA", bus.rdataA, 0);
    chk("abort_ackA", {31'b0, bus.ackA}, 0);
    reset = 1'b0;
    bus.reqA = 1'b1; bus.addrA = 7'd5; bus.reqB = 1'b1; bus.weB = 1'b0; bus.addrB = 7'd9;
    tick();
    chk("post_busy_addr", {25'b0, bus.memAddress}, 5);
    tick();
    chk("post_first_acks", {30'b0, bus.ackA, bus.ackB}, 2'b10);
    bus.reqA = 1'b0;
    tick();
    chk("post_rdataA", bus.rdataA, 32'hDEADBEEF);
    tick();
    chk("post_b_addr", {25'b0, bus.memAddress}, 9);
    tick();
    chk("post_second_acks", {30'b0, bus.ackA, bus.ackB}, 2'b01);
    bus.reqB = 1'b0;
    tick();
    chk("post_rdataB", bus.rdataB, 32'h1000_0009);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
